// File: rtl/bw_io_cmos2_pkg.sv
// Shared types, default parameters and sizing helpers for the CMOS2 pad controller.
package bw_io_cmos2_pkg;

  localparam int DW_DEF       = 8;
  localparam int BIT_CYC_DEF  = 16;
  localparam int TURN_CYC_DEF = 4;

  typedef enum logic [2:0] {
    ST_TURN     = 3'd0,
    ST_IDLE     = 3'd1,
    ST_TX       = 3'd2,
    ST_RX_START = 3'd3,
    ST_RX_DATA  = 3'd4,
    ST_RX_STOP  = 3'd5
  } state_e;

  // Bit index spans start bit, DW data bits and stop bit.
  function automatic int f_bit_w(input int dw);
    return $clog2(dw + 2);
  endfunction

  function automatic int f_half(input int bit_cyc);
    return bit_cyc / 2;
  endfunction

endpackage

// File: rtl/bw_io_cmos2_pad_ctl_if.sv
// Core/pad-side signal bundle for the CMOS2 pad controller; slave = controller, master = core + pad.
interface bw_io_cmos2_pad_ctl_if
  import bw_io_cmos2_pkg::*;
#(
  parameter int DW = DW_DEF
);
  logic          tx_valid;
  logic [DW-1:0] tx_data;
  logic          tx_ready;
  logic          rx_valid;
  logic [DW-1:0] rx_data;
  logic          rx_err;
  logic          pad_oe;
  logic          pad_data;
  logic          pad_in;

  modport master (
    output tx_valid, tx_data, pad_in,
    input  tx_ready, rx_valid, rx_data, rx_err, pad_oe, pad_data
  );

  modport slave (
    input  tx_valid, tx_data, pad_in,
    output tx_ready, rx_valid, rx_data, rx_err, pad_oe, pad_data
  );
endinterface

// File: rtl/bw_io_cmos2_rx_sync.sv
// pad_in synchronizer (2 flops, reset high) with falling-edge detect; 2-cycle latency, no backpressure.
// BW_IO_CMOS2_GLITCH_FILT_EN adds a 3-sample majority filter (+1 cycle) that hides 1-cycle pulses.
module bw_io_cmos2_rx_sync (
  input  logic rclk,
  input  logic arst_l,
  input  logic i_pad_in,
  output logic o_pin_s,
  output logic o_fall
);
  logic r_s1;
  logic r_s2;
  logic r_prev;
  logic w_pin;

  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      r_s1   <= 1'b1;
      r_s2   <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_s1   <= i_pad_in;
      r_s2   <= r_s1;
      r_prev <= w_pin;
    end
  end

`ifdef BW_IO_CMOS2_GLITCH_FILT_EN
  logic r_s3;
  logic r_s4;

  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      r_s3 <= 1'b1;
      r_s4 <= 1'b1;
    end else begin
      r_s3 <= r_s2;
      r_s4 <= r_s3;
    end
  end

  assign w_pin = (r_s2 & r_s3) | (r_s2 & r_s4) | (r_s3 & r_s4);
`else
  assign w_pin = r_s2;
`endif

  assign o_pin_s = w_pin;
  assign o_fall  = r_prev & ~w_pin;
endmodule

// File: rtl/bw_io_cmos2_pad_ctl.sv
// Half-duplex UART-style controller for one CMOS2 pad: frames tx words, deframes pad_in; tx_ready only in IDLE.
// Frame = start, DW bits LSB first, stop; BIT_CYC cycles/bit; BW_IO_CMOS2_GLITCH_FILT_EN enables rx majority filter.
module bw_io_cmos2_pad_ctl
  import bw_io_cmos2_pkg::*;
#(
  parameter int DW       = DW_DEF,
  parameter int BIT_CYC  = BIT_CYC_DEF,
  parameter int TURN_CYC = TURN_CYC_DEF
) (
  input logic                  rclk,
  input logic                  arst_l,
  bw_io_cmos2_pad_ctl_if.slave io
);
  localparam int BW = f_bit_w(DW);
  localparam int CW = $clog2(BIT_CYC);
  localparam int TW = $clog2(TURN_CYC + 1);

  localparam logic [CW-1:0] LP_BIT_LAST  = CW'(BIT_CYC - 1);
  localparam logic [CW-1:0] LP_HALF_LAST = CW'(f_half(BIT_CYC) - 1);
  localparam logic [BW-1:0] LP_TX_STOP   = BW'(DW + 1);
  localparam logic [BW-1:0] LP_TX_LASTD  = BW'(DW);
  localparam logic [BW-1:0] LP_RX_LASTD  = BW'(DW - 1);
  localparam logic [TW-1:0] LP_TURN      = TW'(TURN_CYC);
  localparam logic [TW-1:0] LP_TURN_ONE  = TW'(1);

  state_e        r_state;
  logic [CW-1:0] r_cyc;
  logic [BW-1:0] r_bit;
  logic [TW-1:0] r_turn;
  logic [DW-1:0] r_shift;
  logic [DW-1:0] r_rx_data;
  logic          r_pad_oe;
  logic          r_pad_data;
  logic          r_rx_valid;
  logic          r_rx_err;

  logic          w_pin_s;
  logic          w_fall;
  logic          w_tx_ready;
  logic          w_cyc_done;

  bw_io_cmos2_rx_sync u_rx_sync (
    .rclk     (rclk),
    .arst_l   (arst_l),
    .i_pad_in (io.pad_in),
    .o_pin_s  (w_pin_s),
    .o_fall   (w_fall)
  );

  // An rx start edge wins over a pending tx word, so ready drops in that cycle.
  assign w_tx_ready = (r_state == ST_IDLE) && !w_fall;
  assign w_cyc_done = (r_cyc == '0);

  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      r_state    <= ST_TURN;
      r_cyc      <= '0;
      r_bit      <= '0;
      r_turn     <= LP_TURN;
      r_shift    <= '0;
      r_rx_data  <= '0;
      r_pad_oe   <= 1'b0;
      r_pad_data <= 1'b1;
      r_rx_valid <= 1'b0;
      r_rx_err   <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      r_rx_err   <= 1'b0;
      case (r_state)
        ST_TURN: begin
          if (r_turn <= LP_TURN_ONE) r_state <= ST_IDLE;
          else                       r_turn  <= r_turn - 1'b1;
        end
        ST_IDLE: begin
          if (w_fall) begin
            r_state <= ST_RX_START;
            r_cyc   <= LP_HALF_LAST;
          end else if (io.tx_valid) begin
            r_state    <= ST_TX;
            r_shift    <= io.tx_data;
            r_pad_oe   <= 1'b1;
            r_pad_data <= 1'b0;
            r_cyc      <= LP_BIT_LAST;
            r_bit      <= '0;
          end
        end
        ST_TX: begin
          if (!w_cyc_done) begin
            r_cyc <= r_cyc - 1'b1;
          end else if (r_bit == LP_TX_STOP) begin
            r_pad_oe   <= 1'b0;
            r_pad_data <= 1'b1;
            r_state    <= ST_TURN;
            r_turn     <= LP_TURN;
          end else begin
            r_cyc      <= LP_BIT_LAST;
            r_bit      <= r_bit + 1'b1;
            r_pad_data <= (r_bit == LP_TX_LASTD) ? 1'b1 : r_shift[0];
            r_shift    <= r_shift >> 1;
          end
        end
        ST_RX_START: begin
          if (!w_cyc_done) begin
            r_cyc <= r_cyc - 1'b1;
          end else if (w_pin_s) begin
            r_state <= ST_IDLE;
          end else begin
            r_state <= ST_RX_DATA;
            r_cyc   <= LP_BIT_LAST;
            r_bit   <= '0;
          end
        end
        ST_RX_DATA: begin
          if (!w_cyc_done) begin
            r_cyc <= r_cyc - 1'b1;
          end else begin
            r_shift <= {w_pin_s, r_shift[DW-1:1]};
            r_cyc   <= LP_BIT_LAST;
            r_bit   <= r_bit + 1'b1;
            if (r_bit == LP_RX_LASTD) r_state <= ST_RX_STOP;
          end
        end
        ST_RX_STOP: begin
          if (!w_cyc_done) begin
            r_cyc <= r_cyc - 1'b1;
          end else begin
            if (w_pin_s) begin
              r_rx_data  <= r_shift;
              r_rx_valid <= 1'b1;
            end else begin
              r_rx_err <= 1'b1;
            end
            r_state <= ST_TURN;
            r_turn  <= LP_TURN;
          end
        end
        default: begin
          r_state <= ST_TURN;
          r_turn  <= LP_TURN;
        end
      endcase
    end
  end

  assign io.tx_ready = w_tx_ready;
  assign io.rx_valid = r_rx_valid;
  assign io.rx_data  = r_rx_data;
  assign io.rx_err   = r_rx_err;
  assign io.pad_oe   = r_pad_oe;
  assign io.pad_data = r_pad_data;
endmodule

// File: tb/tb_bw_io_cmos2_pad_ctl.sv
// Directed bench for bw_io_cmos2_pad_ctl (DW=8, BIT_CYC=16, TURN_CYC=4); valid with or without BW_IO_CMOS2_GLITCH_FILT_EN.
module tb_bw_io_cmos2_pad_ctl;
  localparam int DW       = 8;
  localparam int BIT_CYC  = 16;
  localparam int TURN_CYC = 4;

  logic rclk   = 1'b0;
  logic arst_l = 1'b0;
  always #5 rclk = ~rclk;

  bw_io_cmos2_pad_ctl_if #(.DW(DW)) io ();

  bw_io_cmos2_pad_ctl #(
    .DW       (DW),
    .BIT_CYC  (BIT_CYC),
    .TURN_CYC (TURN_CYC)
  ) u_dut (
    .rclk   (rclk),
    .arst_l (arst_l),
    .io     (io)
  );

  int n_chk     = 0;
  int n_pass    = 0;
  int n_valid   = 0;
  int n_err     = 0;
  int n_oe_bad  = 0;
  int cyc       = 0;
  int cyc_valid = 0;
  int cyc_hs    = 0;
  logic [DW-1:0] last_rx = '0;
  logic rx_active = 1'b0;

  always @(negedge rclk) begin
    cyc++;
    if (arst_l) begin
      if (io.rx_valid) begin
        n_valid++;
        last_rx   = io.rx_data;
        cyc_valid = cyc;
      end
      if (io.rx_err) n_err++;
      if (io.pad_oe && rx_active) n_oe_bad++;
      if (io.tx_valid && io.tx_ready) cyc_hs = cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!io.tx_ready && n < 400) begin
      tick();
      n++;
    end
  endtask

  // rx_active covers the part of the frame where the pad must stay released.
  task automatic send_frame(input logic [DW-1:0] d, input logic stop);
    logic [DW+1:0] f;
    f = {stop, d, 1'b0};
    rx_active = 1'b1;
    for (int b = 0; b < DW + 1; b++) begin
      io.pad_in = f[b];
      repeat (BIT_CYC) tick();
    end
    io.pad_in = f[DW+1];
    repeat (BIT_CYC / 2) tick();
    rx_active = 1'b0;
    repeat (BIT_CYC / 2) tick();
    io.pad_in = 1'b1;
    repeat (BIT_CYC) tick();
  endtask

  task automatic capture_tx(output logic [DW-1:0] d, output int oe_n);
    int idx;
    d    = '0;
    oe_n = 0;
    for (int i = 0; i < 400 && io.pad_oe; i++) begin
      if ((i % BIT_CYC) == BIT_CYC / 2) begin
        idx = i / BIT_CYC;
        if (idx >= 1 && idx <= DW) d[idx-1] = io.pad_data;
      end
      oe_n++;
      tick();
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, cycles=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int good;
    int bv, be, bo;
    int oe_n;
    logic [DW-1:0] d;
    logic exp_bits [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    io.tx_valid = 1'b0;
    io.tx_data  = '0;
    io.pad_in   = 1'b1;
    repeat (3) tick();
    chk("rst_pad_oe", io.pad_oe, 0);
    chk("rst_pad_data", io.pad_data, 1);
    chk("rst_tx_ready", io.tx_ready, 0);
    chk("rst_rx_valid", io.rx_valid, 0);
    chk("rst_rx_err", io.rx_err, 0);
    chk("rst_rx_data", io.rx_data, 0);

    arst_l = 1'b1;
    wait_ready(n);
    chk("rst_ready_latency", n, 4);
    chk("idle_pad_oe", io.pad_oe, 0);

    // Transmit 0xA5 and check every cycle of every bit.
    io.tx_data  = 8'hA5;
    io.tx_valid = 1'b1;
    tick();
    io.tx_valid = 1'b0;
    for (int b = 0; b < 10; b++) begin
      good = 0;
      repeat (BIT_CYC) begin
        if (io.pad_oe && io.pad_data == exp_bits[b]) good++;
        tick();
      end
      chk($sformatf("tx_a5_bit%0d", b), good, 16);
    end
    chk("tx_a5_oe_end", io.pad_oe, 0);
    chk("tx_a5_data_end", io.pad_data, 1);
    wait_ready(n);
    chk("tx_a5_turn", n, 4);

    // Framing error: rx_data must keep its reset value.
    bv = n_valid; be = n_err; bo = n_oe_bad;
    send_frame(8'h3C, 1'b0);
    repeat (8) tick();
    chk("err_rx_err_cnt", n_err - be, 1);
    chk("err_rx_valid_cnt", n_valid - bv, 0);
    chk("err_rx_data_hold", io.rx_data, 0);
    chk("err_pad_oe", n_oe_bad - bo, 0);

    // Good 0x3C frame.
    wait_ready(n);
    bv = n_valid; be = n_err; bo = n_oe_bad;
    send_frame(8'h3C, 1'b1);
    repeat (8) tick();
    chk("rx_valid_cnt", n_valid - bv, 1);
    chk("rx_data_pulse", last_rx, 8'h3C);
    chk("rx_data_hold", io.rx_data, 8'h3C);
    chk("rx_err_cnt", n_err - be, 0);
    chk("rx_pad_oe", n_oe_bad - bo, 0);

    // Collision: tx_valid raised in the cycle the start edge is seen.
    wait_ready(n);
    bv = n_valid; be = n_err; bo = n_oe_bad;
    d = '0; oe_n = 0;
    fork
      send_frame(8'hC3, 1'b1);
      begin
        int k;
        k = 0;
        tick();
        while (io.tx_ready && k < 10) begin
          tick();
          k++;
        end
        io.tx_data  = 8'h11;
        io.tx_valid = 1'b1;
        k = 0;
        tick();
        while (!io.tx_ready && k < 400) begin
          tick();
          k++;
        end
        tick();
        io.tx_valid = 1'b0;
        capture_tx(d, oe_n);
      end
    join
    chk("col_rx_valid_cnt", n_valid - bv, 1);
    chk("col_rx_data", last_rx, 8'hC3);
    chk("col_rx_err_cnt", n_err - be, 0);
    chk("col_pad_oe_in_frame", n_oe_bad - bo, 0);
    chk("col_hs_after_turn", cyc_hs - cyc_valid, 4);
    chk("col_tx_data", d, 8'h11);
    chk("col_tx_oe_cycles", oe_n, 160);

    // One-cycle low pulse on pad_in must produce nothing.
    wait_ready(n);
    bv = n_valid; be = n_err;
    io.pad_in = 1'b0;
    tick();
    io.pad_in = 1'b1;
    repeat (40) tick();
    chk("glitch_rx_valid", n_valid - bv, 0);
    chk("glitch_rx_err", n_err - be, 0);
    chk("glitch_back_idle", io.tx_ready, 1);

    // Reset in the middle of data bit 4 of a transmission.
    io.tx_data  = 8'h5A;
    io.tx_valid = 1'b1;
    tick();
    io.tx_valid = 1'b0;
    repeat (4 * BIT_CYC + BIT_CYC / 2) tick();
    chk("midtx_pad_oe", io.pad_oe, 1);
    #1 arst_l = 1'b0;
    #1;
    chk("async_rst_pad_oe", io.pad_oe, 0);
    chk("async_rst_pad_data", io.pad_data, 1);
    chk("async_rst_tx_ready", io.tx_ready, 0);
    tick();
    tick();
    arst_l = 1'b1;
    wait_ready(n);
    chk("rerst_ready_latency", n, 4);
    chk("rerst_rx_valid", n_valid - bv, 0);
    chk("rerst_rx_err", n_err - be, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
